// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: sequences an i2c_slave byte stream into an 8-bit register bank.
// Ports: txn/wr/rd slave side, host_* local port, regs_o/strobes/err_o/busy_o.
module i2c_reg_ctrl #(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  localparam int         AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  txn_start_i,
  input  logic                  txn_stop_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  wr_valid_i,
  output logic [7:0]            rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  input  logic                  host_we_i,
  input  logic [AW-1:0]         host_addr_i,
  input  logic [7:0]            host_wdata_i,
  output logic [7:0]            host_rdata_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic [NUM_REGS-1:0]   reg_wr_strobe_o,
  output logic                  err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_DATA,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]          r_regs [NUM_REGS];
  logic [AW-1:0]       r_ptr;
  logic [7:0]          r_rd_data;
  logic [7:0]          r_host_rdata;
  logic                r_rd_valid;
  logic                r_err;
  logic [NUM_REGS-1:0] r_strobe;

  logic w_ev_stop;
  logic w_ev_start;
  logic w_ev_wr;
  logic w_ev_rd;
  logic w_in_range;
  logic w_i2c_wr;
  logic w_ptr_ld;
  logic w_ptr_inc;
  logic w_err;

  // Lower-priority events are masked by any higher one.
  assign w_ev_stop  = txn_stop_i;
  assign w_ev_start = txn_start_i & ~txn_stop_i;
  assign w_ev_wr    = wr_valid_i & ~txn_start_i & ~txn_stop_i;
  assign w_ev_rd    = rd_ready_i & ~wr_valid_i
                    & ~txn_start_i & ~txn_stop_i;
  assign w_in_range = ({1'b0, wr_data_i} < 9'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_ev_stop)       w_next = S_IDLE;
    else if (w_ev_start) w_next = S_PTR;
    else if (r_state == S_PTR) begin
      if (w_ev_wr)      w_next = w_in_range ? S_DATA : S_ERR;
      else if (w_ev_rd) w_next = S_DATA;
    end
  end

  always_comb begin
    w_i2c_wr  = 1'b0;
    w_ptr_ld  = 1'b0;
    w_ptr_inc = 1'b0;
    w_err     = 1'b0;
    unique case (1'b1)
      (r_state == S_PTR): begin
        w_ptr_ld  = w_ev_wr & w_in_range;
        w_err     = w_ev_wr & ~w_in_range;
        w_ptr_inc = w_ev_rd;
      end
      (r_state == S_DATA): begin
        w_i2c_wr  = w_ev_wr;
        w_ptr_inc = w_ev_wr | w_ev_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_rd_data    <= RESET_VAL;
      r_host_rdata <= RESET_VAL;
      r_rd_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_strobe     <= '0;
      for (int k = 0; k < NUM_REGS; k++)
        r_regs[k] <= RESET_VAL;
    end else begin
      if (w_ptr_ld)
        r_ptr <= wr_data_i[AW-1:0];
      else if (w_ptr_inc)
        r_ptr <= r_ptr + AW'(1);
      // I2C write takes the slot; host write to the same index drops.
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_i2c_wr && r_ptr == AW'(k))
          r_regs[k] <= wr_data_i;
        else if (host_we_i && host_addr_i == AW'(k))
          r_regs[k] <= host_wdata_i;
      end
      r_strobe     <= w_i2c_wr ? (NUM_REGS'(1) << r_ptr) : '0;
      r_err        <= w_err;
      r_rd_valid   <= (w_next == S_PTR) || (w_next == S_DATA);
      r_rd_data    <= r_regs[r_ptr];
      r_host_rdata <= r_regs[host_addr_i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[8*g +: 8] = r_regs[g];
  end

  assign rd_data_o       = r_rd_data;
  assign rd_valid_o      = r_rd_valid;
  assign host_rdata_o    = r_host_rdata;
  assign reg_wr_strobe_o = r_strobe;
  assign err_o           = r_err;
  assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: directed bench for i2c_reg_ctrl (NUM_REGS=16).
// One task per scenario, inline checks, single summary line.
module tb_i2c_reg_ctrl;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           txn_start_i = 1'b0;
  logic           txn_stop_i = 1'b0;
  logic [7:0]     wr_data_i = 8'h00;
  logic           wr_valid_i = 1'b0;
  logic [7:0]     rd_data_o;
  logic           rd_valid_o;
  logic           rd_ready_i = 1'b0;
  logic           host_we_i = 1'b0;
  logic [3:0]     host_addr_i = 4'd0;
  logic [7:0]     host_wdata_i = 8'h00;
  logic [7:0]     host_rdata_o;
  logic [N*8-1:0] regs_o;
  logic [N-1:0]   reg_wr_strobe_o;
  logic           err_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] m [N];

  i2c_reg_ctrl #(.NUM_REGS(N), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .txn_start_i(txn_start_i), .txn_stop_i(txn_stop_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i),
    .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o),
    .regs_o(regs_o), .reg_wr_strobe_o(reg_wr_strobe_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [N*8-1:0] flat();
    logic [N*8-1:0] r;
    for (int k = 0; k < N; k++) r[8*k +: 8] = m[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_p();
    txn_start_i = 1'b1; tick(); txn_start_i = 1'b0;
  endtask

  task automatic stop_p();
    txn_stop_i = 1'b1; tick(); txn_stop_i = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] b);
    wr_data_i = b; wr_valid_i = 1'b1; tick(); wr_valid_i = 1'b0;
  endtask

  task automatic rdy();
    rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
  endtask

  task automatic hwr(input logic [3:0] a, input logic [7:0] d);
    host_addr_i = a; host_wdata_i = d; host_we_i = 1'b1;
    tick();
    host_we_i = 1'b0;
    m[a] = d;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) m[k] = 8'h00;
    rst_n = 1'b0; tick(); tick();
    checks++; if (regs_o !== flat()) begin errors++;
      $display("FAIL rst_regs got %h exp %h", regs_o, flat()); end
    checks++; if (rd_data_o !== 8'h00) begin errors++;
      $display("FAIL rst_rd_data got %h exp 00", rd_data_o); end
    checks++; if (host_rdata_o !== 8'h00) begin errors++;
      $display("FAIL rst_host_rdata got %h exp 00", host_rdata_o); end
    checks++; if ({rd_valid_o, err_o, busy_o} !== 3'b000) begin errors++;
      $display("FAIL rst_flags got %b exp 000", {rd_valid_o, err_o, busy_o}); end
    checks++; if (reg_wr_strobe_o !== 16'h0) begin errors++;
      $display("FAIL rst_strobe got %h exp 0000", reg_wr_strobe_o); end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < N; k++) hwr(4'(k), 8'(8'h40 + k));
  endtask

  task automatic test_write_burst();
    start_p();
    checks++; if ({busy_o, rd_valid_o} !== 2'b11) begin errors++;
      $display("FAIL wb_start got %b exp 11", {busy_o, rd_valid_o}); end
    wbyte(8'h03);
    checks++; if (reg_wr_strobe_o !== 16'h0) begin errors++;
      $display("FAIL wb_ptr_strobe got %h exp 0000", reg_wr_strobe_o); end
    wbyte(8'hA5); m[3] = 8'hA5;
    checks++; if (regs_o !== flat() || reg_wr_strobe_o !== 16'h0008) begin
      errors++;
      $display("FAIL wb_byte1 got %h/%h exp %h/0008",
               regs_o, reg_wr_strobe_o, flat()); end
    wbyte(8'h5A); m[4] = 8'h5A;
    checks++; if (regs_o !== flat() || reg_wr_strobe_o !== 16'h0010) begin
      errors++;
      $display("FAIL wb_byte2 got %h/%h exp %h/0010",
               regs_o, reg_wr_strobe_o, flat()); end
    tick();
    checks++; if (reg_wr_strobe_o !== 16'h0 || rd_data_o !== 8'h45) begin
      errors++;
      $display("FAIL wb_ptr5 got %h/%h exp 0000/45",
               reg_wr_strobe_o, rd_data_o); end
    stop_p();
    checks++; if ({busy_o, rd_valid_o} !== 2'b00) begin errors++;
      $display("FAIL wb_stop got %b exp 00", {busy_o, rd_valid_o}); end
  endtask

  task automatic test_ptr_read();
    hwr(4'd14, 8'h11); hwr(4'd15, 8'h22); hwr(4'd0, 8'h33);
    start_p();
    wbyte(8'h0E);
    start_p();
    checks++; if (rd_data_o !== 8'h11) begin errors++;
      $display("FAIL rd_0 got %h exp 11", rd_data_o); end
    rdy(); tick();
    checks++; if (rd_data_o !== 8'h22) begin errors++;
      $display("FAIL rd_1 got %h exp 22", rd_data_o); end
    rdy(); tick();
    checks++; if (rd_data_o !== 8'h33) begin errors++;
      $display("FAIL rd_2_wrap got %h exp 33", rd_data_o); end
    rdy(); tick();
    checks++; if (rd_data_o !== 8'h41 || rd_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_ptr1 got %h/%b exp 41/1", rd_data_o, rd_valid_o); end
    stop_p();
  endtask

  task automatic test_out_of_range();
    start_p();
    wbyte(8'h20);
    checks++; if (err_o !== 1'b1) begin errors++;
      $display("FAIL oor_err got %b exp 1", err_o); end
    tick();
    checks++; if ({err_o, busy_o, rd_valid_o} !== 3'b010) begin errors++;
      $display("FAIL oor_errstate got %b exp 010",
               {err_o, busy_o, rd_valid_o}); end
    wbyte(8'h77);
    checks++; if (regs_o !== flat() || reg_wr_strobe_o !== 16'h0
                  || err_o !== 1'b0) begin errors++;
      $display("FAIL oor_nowrite got %h/%h/%b exp %h/0000/0",
               regs_o, reg_wr_strobe_o, err_o, flat()); end
    stop_p();
    tick();
    checks++; if (busy_o !== 1'b0 || rd_data_o !== 8'h41) begin errors++;
      $display("FAIL oor_ptr_kept got %b/%h exp 0/41", busy_o, rd_data_o); end
  endtask

  task automatic test_collision();
    start_p();
    wbyte(8'h02);
    wr_data_i = 8'hC3; wr_valid_i = 1'b1;
    host_we_i = 1'b1; host_addr_i = 4'd2; host_wdata_i = 8'h3C;
    tick();
    wr_data_i = 8'h5E;
    host_addr_i = 4'd9; host_wdata_i = 8'hAB;
    tick();
    wr_valid_i = 1'b0;
    host_addr_i = 4'd7; host_wdata_i = 8'h99;
    tick();
    host_we_i = 1'b0;
    m[2] = 8'hC3; m[3] = 8'h5E; m[9] = 8'hAB; m[7] = 8'h99;
    checks++; if (regs_o[23:16] !== 8'hC3) begin errors++;
      $display("FAIL col_reg2 got %h exp C3", regs_o[23:16]); end
    checks++; if (regs_o !== flat()) begin errors++;
      $display("FAIL col_regs got %h exp %h", regs_o, flat()); end
    host_addr_i = 4'd2; tick();
    checks++; if (host_rdata_o !== 8'hC3) begin errors++;
      $display("FAIL col_hrd2 got %h exp C3", host_rdata_o); end
    host_addr_i = 4'd7; tick();
    checks++; if (host_rdata_o !== 8'h99) begin errors++;
      $display("FAIL col_hrd7 got %h exp 99", host_rdata_o); end
    stop_p();
  endtask

  task automatic test_simultaneous();
    txn_start_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'h05;
    tick();
    txn_start_i = 1'b0; wr_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || reg_wr_strobe_o !== 16'h0
                  || regs_o !== flat()) begin errors++;
      $display("FAIL sim_start_wr got %b/%h exp 1/0000",
               busy_o, reg_wr_strobe_o); end
    wbyte(8'h06);
    wbyte(8'hEE); m[6] = 8'hEE;
    checks++; if (reg_wr_strobe_o !== 16'h0040 || regs_o !== flat()) begin
      errors++;
      $display("FAIL sim_ptr_then_data got %h/%h exp 0040/%h",
               reg_wr_strobe_o, regs_o, flat()); end
    txn_start_i = 1'b1; txn_stop_i = 1'b1;
    tick();
    txn_start_i = 1'b0; txn_stop_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || rd_valid_o !== 1'b0) begin errors++;
      $display("FAIL sim_stop_start got %b/%b exp 0/0", busy_o, rd_valid_o); end
    wbyte(8'h01);
    checks++; if (reg_wr_strobe_o !== 16'h0 || regs_o !== flat()) begin
      errors++;
      $display("FAIL sim_idle_ignore got %h exp 0000", reg_wr_strobe_o); end
  endtask

  task automatic test_reset_mid_burst();
    start_p();
    wbyte(8'h05);
    wbyte(8'hFF);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < N; k++) m[k] = 8'h00;
    checks++; if (regs_o !== flat()) begin errors++;
      $display("FAIL mrst_regs got %h exp %h", regs_o, flat()); end
    checks++; if ({busy_o, rd_valid_o, err_o} !== 3'b000
                  || reg_wr_strobe_o !== 16'h0) begin errors++;
      $display("FAIL mrst_flags got %b/%h exp 000/0000",
               {busy_o, rd_valid_o, err_o}, reg_wr_strobe_o); end
    checks++; if (rd_data_o !== 8'h00 || host_rdata_o !== 8'h00) begin
      errors++;
      $display("FAIL mrst_rdata got %h/%h exp 00/00",
               rd_data_o, host_rdata_o); end
    hwr(4'd0, 8'h5C);
    tick();
    checks++; if (rd_data_o !== 8'h5C) begin errors++;
      $display("FAIL mrst_ptr0 got %h exp 5C", rd_data_o); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_ptr_read();
    test_out_of_range();
    test_collision();
    test_simultaneous();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
